// File: rtl/ampa_apb_mem_if.sv
// APB bus bundle for ampa_apb_mem: master drives request, slave returns completion.
interface ampa_apb_mem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0]   P_addr;
  logic                P_selx;
  logic                P_enable;
  logic                P_write;
  logic [DATA_W-1:0]   P_wdata;
  logic [DATA_W/8-1:0] P_strb;
  logic                P_ready;
  logic                P_slverr;
  logic [DATA_W-1:0]   P_rdata;

  modport master (
    output P_addr, P_selx, P_enable, P_write, P_wdata, P_strb,
    input  P_ready, P_slverr, P_rdata
  );

  modport slave (
    input  P_addr, P_selx, P_enable, P_write, P_wdata, P_strb,
    output P_ready, P_slverr, P_rdata
  );
endinterface

// File: rtl/ampa_apb_mem.sv
// Parametrised APB slave word memory with byte-lane writes, programmable wait
// states and PSLVERR on misaligned or out-of-range accesses.
module ampa_apb_mem #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic           P_clk,
  input logic           P_rst,
  ampa_apb_mem_if.slave bus
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned B     = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(LANES - 1);
  localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LANES-1:0]  strb_q, strb_d;
  logic              err_q, err_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              slverr_q, slverr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;

  logic [ADDR_W-1:0] bus_word;
  logic              bus_err;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_word;

  // Range check on the full address so high address bits never alias into the array.
  assign bus_word = bus.P_addr >> B;
  assign bus_err  = ((bus.P_addr & LANE_MASK) != '0) || (64'(bus_word) >= 64'(DEPTH));

  // With zero wait states the read happens on the setup edge, before idx_q is valid.
  assign rd_idx  = (state_q == S_IDLE) ? bus_word[IDX_W-1:0] : idx_q;
  assign rd_word = mem[rd_idx];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    slverr_d = 1'b0;
    rdata_d  = '0;
    mem_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.P_selx && !bus.P_enable) begin
          state_d = S_ACCESS;
          idx_d   = bus_word[IDX_W-1:0];
          write_d = bus.P_write;
          wdata_d = bus.P_wdata;
          strb_d  = bus.P_strb;
          err_d   = bus_err;
          cnt_d   = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            ready_d  = 1'b1;
            slverr_d = bus_err;
            if (!bus.P_write && !bus_err) rdata_d = rd_word;
          end
        end
      end
      S_ACCESS: begin
        if (ready_q) begin
          state_d = S_IDLE;
          mem_we  = write_q && !err_q;
        end else if (!bus.P_selx || !bus.P_enable) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            ready_d  = 1'b1;
            slverr_d = err_q;
            if (!write_q && !err_q) rdata_d = rd_word;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge P_clk) begin
    if (P_rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is never reset; a reset coinciding with the completion edge suppresses the write.
  always_ff @(posedge P_clk) begin
    if (mem_we && !P_rst) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.P_ready  = ready_q;
  assign bus.P_slverr = slverr_q;
  assign bus.P_rdata  = rdata_q;

  a_resp_only_with_ready: assert property (@(posedge P_clk) disable iff (P_rst)
    !bus.P_ready |-> (!bus.P_slverr && (bus.P_rdata == '0)));
  a_ready_single_cycle: assert property (@(posedge P_clk) disable iff (P_rst)
    bus.P_ready |=> !bus.P_ready);

endmodule

// File: doc/ampa_apb_mem.md
Name: ampa_apb_mem

Overview:
Parametrised APB slave with on-chip word memory. It is the next generation of our fixed 32x32 APB memory slave.
- Adds generic data width and depth.
- Adds byte-addressing with PSTRB byte-lane writes.
- Adds programmable wait states and PSLVERR on illegal accesses.
- Uses fully registered handshake outputs.
It sits on the peripheral bus behind the APB bridge as a scratch/config RAM.

Parameters:
DATA_W, 32, data bus width in bits; multiple of 8, minimum 8.
ADDR_W, 32, P_addr width in bits.
DEPTH, 32, number of DATA_W-bit words; need not be a power of two.
WAIT_CYCLES, 0, wait states inserted in every ACCESS phase before P_ready; range 0..15.

Ports:
P_clk  in  1  bus clock; all logic on the rising edge.
P_rst  in  1  synchronous active-high reset.
P_addr  in  ADDR_W  byte address.
P_selx  in  1  slave select.
P_enable  in  1  APB enable (ACCESS phase).
P_write  in  1  1 = write, 0 = read.
P_wdata  in  DATA_W  write data.
P_strb  in  DATA_W/8  write byte-lane strobes; ignored on reads.
P_ready  out  1  transfer completes in the cycle this is high.
P_slverr  out  1  error response; valid only while P_ready=1, otherwise 0.
P_rdata  out  DATA_W  read data; valid only while P_ready=1 on a read, otherwise 0.

Behaviour:
- Reset: while P_rst=1 at a clock edge, state goes to IDLE and P_ready, P_slverr and P_rdata all become 0.
  - Memory contents are not reset and are undefined after power-up.
  - Reset during any phase aborts the transfer; no memory write occurs.
- Address decode, with B = log2(DATA_W/8):
  - word index = P_addr >> B.
  - Misaligned: P_addr[B-1:0] != 0.
  - Out of range: index >= DEPTH, evaluated on the full ADDR_W address, so no aliasing.
  - Error = misaligned OR out of range.
- States: IDLE, ACCESS. The setup phase is the cycle IDLE samples P_selx=1 and P_enable=0.
- IDLE:
  - On P_selx & !P_enable, capture addr/write/wdata/strb and the error flag, load wait counter = WAIT_CYCLES, go to ACCESS.
  - Any other input stays in IDLE; a spurious P_enable with P_selx=0 is ignored.
- Entry to ACCESS:
  - P_ready <= (WAIT_CYCLES==0).
  - If WAIT_CYCLES==0, P_rdata and P_slverr are also loaded on the same edge, so they are valid together with P_ready.
- ACCESS, P_ready=0:
  - If P_selx=0 or P_enable=0 (protocol abort), go to IDLE with no write and outputs 0.
  - Otherwise decrement the counter.
  - When the counter reaches 0, P_ready <= 1 with P_rdata and P_slverr loaded on the same edge.
  - Exactly WAIT_CYCLES ACCESS cycles have P_ready low.
- ACCESS, P_ready=1 (completion cycle):
  - Write: on that edge, update only lanes with P_strb[i]=1, mem[idx][8i+7:8i] <= wdata lane.
  - Error write: nothing is written.
  - Next state is IDLE; P_ready, P_slverr and P_rdata return to 0.
- Read data:
  - Taken from memory when P_rdata is loaded.
  - Error read returns P_rdata = 0 with P_slverr = 1.
  - Read with no error: P_slverr = 0.
- Latency:
  - Setup to completion = WAIT_CYCLES+1 ACCESS cycles.
  - Minimum transfer is 2 cycles; back-to-back transfers are 2 cycles each, since IDLE accepts a new setup in the cycle right after completion.
- Address, control and wdata are captured at setup, so bus changes during ACCESS have no effect.
- Reading a word in the cycle after it was written returns the new data.

Test Plan:
- DATA_W=32, DEPTH=32, WAIT=0: write 0xDEADBEEF to addr 0x08 (P_strb=0xF), then read 0x08 -> P_ready high in the 2nd cycle of each transfer; read P_rdata=0xDEADBEEF; P_slverr=0.
- Byte strobes: write 0x11223344 to 0x10 with strb=0xF, then 0xAABBCCDD with strb=0x5, then read 0x10 -> 0x11BB33DD.
- Errors: write to 0x80 (out of range), write to 0x0A (misaligned), read 0x1000 -> each completes with P_ready=1, P_slverr=1, read P_rdata=0. Read 0x00 afterwards is unchanged.
- WAIT_CYCLES=3: read of 0x04 -> P_ready low for 3 ACCESS cycles, high on the 4th; P_rdata valid only then. Back-to-back read+write take 5 cycles each.
- Abort and reset: drop P_enable mid-wait (WAIT=3) on a write -> return to IDLE, memory unchanged, P_ready never asserted. Assert P_rst during ACCESS -> next cycle all outputs 0, and a fresh transfer completes normally.
- Depth/width: DATA_W=64, DEPTH=20: write last word addr 0x98, then 0xA0 -> first OK, second P_slverr=1; readback of 0x98 matches with all 8 lanes.
